cmd_word_emitter: RTL and testbench

CMD_WORD_EMITTER -- requirements
Module: cmd_word_emitter

---
 rtl/cmd_word_pkg.sv | 60 ++++++
 rtl/cmd_word_fifo.sv | 87 ++++++++
 rtl/cmd_word_emitter.sv | 149 ++++++++++++++
 tb/tb_cmd_word_emitter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cmd_word_pkg.sv
// Shared field layout for 32-bit command words, used by the parser and the emitter.
// No logic: constants, index helpers and the opcode type only.
// No handshake of its own.
//
// Word layout (bit positions):
//   [2:0]   s1 register number (low 3 bits)   [3]  s1 pointer bit
//   [6:4]   s0 register number                 [7]  s0 pointer bit
//   [10:8]  d  register number                 [11] d  pointer bit
//   [14:12] cnd register number                [15] cnd pointer bit
//   [23:16] flags s1/s0/d/cnd, 2 bits each (s1 lowest)
//   [27:24] reserved, always zero
//   [31:28] cmd_code
package cmd_word_pkg;

  localparam int WORD_W      = 32;
  localparam int REG_NUM_W   = 4;   // width of each incoming register number
  localparam int REG_FIELD_W = 3;   // width kept in the word; the top bit is dropped
  localparam int FLAG_W      = 2;
  localparam int CMD_CODE_W  = 4;

  // Operand order inside the incoming bundles {cnd,d,s0,s1}: s1 sits lowest.
  localparam int IDX_S1  = 0;
  localparam int IDX_S0  = 1;
  localparam int IDX_D   = 2;
  localparam int IDX_CND = 3;

  // Register-number fields and their pointer bits.
  localparam int S1_LSB      = 0;
  localparam int S1_PTR_BIT  = 3;
  localparam int S0_LSB      = 4;
  localparam int S0_PTR_BIT  = 7;
  localparam int D_LSB       = 8;
  localparam int D_PTR_BIT   = 11;
  localparam int CND_LSB     = 12;
  localparam int CND_PTR_BIT = 15;

  // Flag fields.
  localparam int S1_FLAG_LSB  = 16;
  localparam int S0_FLAG_LSB  = 18;
  localparam int D_FLAG_LSB   = 20;
  localparam int CND_FLAG_LSB = 22;

  // Reserved gap and opcode.
  localparam int RSVD_LSB     = 24;
  localparam int RSVD_W       = 4;
  localparam int CMD_CODE_LSB = 28;

  typedef logic [CMD_CODE_W-1:0] cmd_code_t;

  // LSB of operand idx inside the packed register-number bundle.
  function automatic int reg_num_lsb(input int idx);
    return idx * REG_NUM_W;
  endfunction

  // LSB of operand idx inside the packed flag bundle.
  function automatic int flag_lsb(input int idx);
    return idx * FLAG_W;
  endfunction

endpackage : cmd_word_pkg

// File: rtl/cmd_word_fifo.sv
// Command-word buffer: DEPTH x 32 circular FIFO with occupancy count.
// Latency: a write is readable from the next cycle; read data is the head, combinational.
// Backpressure: writes when full and reads when empty are ignored; flush empties it next cycle.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush_i            drop all entries (overrides same-cycle write/read)
//   wr_en_i, wr_data_i write strobe and word
//   rd_en_i            advance the head
//   rd_data_o          head word (undefined content when empty; caller masks it)
//   level_o            number of stored words, 0..DEPTH
module cmd_word_fifo
  import cmd_word_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WORD_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  output logic [WORD_W-1:0]        rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Indices are exactly PTR_W bits, so with DEPTH a power of two they wrap
  // modulo DEPTH on their own; full/empty comes from the level count.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic wr_ok;
  logic rd_ok;

  assign wr_ok = wr_en_i && (level_q != FULL_LVL);
  assign rd_ok = rd_en_i && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because the
  // count, not the array, decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

endmodule : cmd_word_fifo

// File: rtl/cmd_word_emitter.sv
// Packs register/flag/opcode fields into 32-bit command words, buffers them and emits each with an address.
// Latency: one cycle from accepted bundle to out_valid; no bypass.
// Backpressure: in_ready drops when DEPTH words are buffered; output holds while out_ready is low.
//
// Optional build macro: CMD_WORD_FIELD_CHECK_EN -- adds the register-number range check driving err.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       input handshake for one field bundle
//   in_reg_num[15:0]          register numbers {cnd,d,s0,s1}, 4 bits each (bit 3 dropped)
//   in_reg_ptr[3:0]           pointer bits {cnd,d,s0,s1}
//   in_reg_flags[7:0]         2-bit flags {cnd,d,s0,s1}
//   in_cmd_code[3:0]          opcode
//   flush                     discard all buffered words (address counter kept)
//   load_base / base_addr     reload the address counter
//   out_valid / out_ready     output handshake
//   out_word[31:0]            packed command word at the head
//   out_addr[ADDR_W-1:0]      address of the head word
//   level                     buffered word count
//   err                       one-cycle pulse: pushed bundle had an out-of-range register number
module cmd_word_emitter
  import cmd_word_pkg::*;
#(
  parameter int DEPTH  = 4,   // power of two, >= 2
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             in_reg_num,
  input  logic [3:0]              in_reg_ptr,
  input  logic [7:0]              in_reg_flags,
  input  logic [CMD_CODE_W-1:0]   in_cmd_code,
  input  logic                    flush,
  input  logic                    load_base,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W-1:0]       out_word,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    err
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [LVL_W-1:0]  level_w;
  logic [WORD_W-1:0] head_word;
  logic [WORD_W-1:0] packed_word;
  logic              push;
  logic              pop;
  cmd_code_t         cmd_code;

  logic [ADDR_W-1:0] addr_q, addr_d;

  assign cmd_code  = cmd_code_t'(in_cmd_code);
  assign in_ready  = (level_w < FULL_LVL);
  assign out_valid = (level_w != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Field packing. Only the low three bits of each register number are kept.
  always_comb begin
    packed_word = '0;
    packed_word[S1_LSB  +: REG_FIELD_W] = in_reg_num[reg_num_lsb(IDX_S1)  +: REG_FIELD_W];
    packed_word[S0_LSB  +: REG_FIELD_W] = in_reg_num[reg_num_lsb(IDX_S0)  +: REG_FIELD_W];
    packed_word[D_LSB   +: REG_FIELD_W] = in_reg_num[reg_num_lsb(IDX_D)   +: REG_FIELD_W];
    packed_word[CND_LSB +: REG_FIELD_W] = in_reg_num[reg_num_lsb(IDX_CND) +: REG_FIELD_W];
    packed_word[S1_PTR_BIT]  = in_reg_ptr[IDX_S1];
    packed_word[S0_PTR_BIT]  = in_reg_ptr[IDX_S0];
    packed_word[D_PTR_BIT]   = in_reg_ptr[IDX_D];
    packed_word[CND_PTR_BIT] = in_reg_ptr[IDX_CND];
    packed_word[S1_FLAG_LSB  +: FLAG_W] = in_reg_flags[flag_lsb(IDX_S1)  +: FLAG_W];
    packed_word[S0_FLAG_LSB  +: FLAG_W] = in_reg_flags[flag_lsb(IDX_S0)  +: FLAG_W];
    packed_word[D_FLAG_LSB   +: FLAG_W] = in_reg_flags[flag_lsb(IDX_D)   +: FLAG_W];
    packed_word[CND_FLAG_LSB +: FLAG_W] = in_reg_flags[flag_lsb(IDX_CND) +: FLAG_W];
    packed_word[RSVD_LSB     +: RSVD_W] = '0;
    packed_word[CMD_CODE_LSB +: CMD_CODE_W] = cmd_code;
  end

  cmd_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .wr_en_i   (push),
    .wr_data_i (packed_word),
    .rd_en_i   (pop),
    .rd_data_o (head_word),
    .level_o   (level_w)
  );

  // Array contents are not reset, so the head is forced to zero when empty.
  assign out_word = out_valid ? head_word : '0;
  assign level    = level_w;

  // Address counter: tracks the address of the head word. A reload wins over
  // the increment; a flush cancels the pop, so the counter stays put.
  always_comb begin
    addr_d = addr_q;
    if (load_base) begin
      addr_d = base_addr;
    end else if (pop && !flush) begin
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign out_addr = addr_q;

`ifdef CMD_WORD_FIELD_CHECK_EN
  // Flag any register number with its top bit set; the word itself is still
  // accepted with that bit dropped.
  logic err_q, err_d;

  always_comb begin
    err_d = push && (in_reg_num[reg_num_lsb(IDX_S1)  + REG_NUM_W - 1] ||
                     in_reg_num[reg_num_lsb(IDX_S0)  + REG_NUM_W - 1] ||
                     in_reg_num[reg_num_lsb(IDX_D)   + REG_NUM_W - 1] ||
                     in_reg_num[reg_num_lsb(IDX_CND) + REG_NUM_W - 1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // Top bits of the register numbers are intentionally dropped in this build.
  logic unused_reg_num_msb;
  assign unused_reg_num_msb = ^{in_reg_num[15], in_reg_num[11], in_reg_num[7], in_reg_num[3]};
  assign err = 1'b0;
`endif

endmodule : cmd_word_emitter

// File: tb/tb_cmd_word_emitter.sv
// Directed bench for cmd_word_emitter (DEPTH=4, ADDR_W=16).
// Inputs change 1 time unit after a rising edge; outputs are checked in the same window.
// Err expectations follow CMD_WORD_FIELD_CHECK_EN.
module tb_cmd_word_emitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_reg_num;
  logic [3:0]  in_reg_ptr;
  logic [7:0]  in_reg_flags;
  logic [3:0]  in_cmd_code;
  logic        flush;
  logic        load_base;
  logic [15:0] base_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [15:0] out_addr;
  logic [2:0]  level;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CMD_WORD_FIELD_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  cmd_word_emitter #(.DEPTH(4), .ADDR_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reg_num   (in_reg_num),
    .in_reg_ptr   (in_reg_ptr),
    .in_reg_flags (in_reg_flags),
    .in_cmd_code  (in_cmd_code),
    .flush        (flush),
    .load_base    (load_base),
    .base_addr    (base_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word     (out_word),
    .out_addr     (out_addr),
    .level        (level),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_reg_num = '0; in_reg_ptr = '0; in_reg_flags = '0;
    in_cmd_code = '0; flush = 1'b0; load_base = 1'b0; base_addr = '0; out_ready = 1'b0;
    step(); step();

    // Reset state
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_word", out_word, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    step();

    // Scenario 1: opcode-only word, no same-cycle bypass
    in_valid = 1'b1; in_cmd_code = 4'hA;
    chk("s1_no_bypass", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("s1_out_valid", 32'(out_valid), 32'd1);
    chk("s1_out_word", out_word, 32'hA000_0000);
    chk("s1_out_addr", 32'(out_addr), 32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("s1_level_after_pop", 32'(level), 32'd0);
    chk("s1_addr_after_pop", 32'(out_addr), 32'h1);

    // Full packing and FIFO order: A = 0xA039CBA9, B = 0x30E47E5C
    in_valid = 1'b1; in_reg_num = 16'h4321; in_reg_ptr = 4'hF; in_reg_flags = 8'h39; in_cmd_code = 4'hA;
    step();
    in_reg_num = 16'h7654; in_reg_ptr = 4'b0101; in_reg_flags = 8'hE4; in_cmd_code = 4'h3;
    chk("pack_a_head", out_word, 32'hA039_CBA9);
    step();
    in_valid = 1'b0; in_reg_num = '0; in_reg_ptr = '0; in_reg_flags = '0; in_cmd_code = '0;
    chk("pack_level2", 32'(level), 32'd2);
    chk("pack_a_held", out_word, 32'hA039_CBA9);
    out_ready = 1'b1;
    step();
    chk("pack_b_word", out_word, 32'h30E4_7E5C);
    chk("pack_b_addr", 32'(out_addr), 32'h2);
    step();
    out_ready = 1'b0;
    chk("pack_drained", 32'(out_valid), 32'd0);
    chk("pack_addr3", 32'(out_addr), 32'h3);

    // Scenario 2: fill to DEPTH, fifth bundle held until a pop
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_cmd_code = 4'(i);
      step();
      chk("fill_level", 32'(level), 32'(i + 1));
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_cmd_code = 4'h4;
    step();
    chk("full_level_held", 32'(level), 32'd4);
    chk("full_head_w0", out_word, 32'h0000_0000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("full_pop_level", 32'(level), 32'd3);
    chk("full_pop_in_ready", 32'(in_ready), 32'd1);
    chk("full_head_w1", out_word, 32'h1000_0000);
    chk("full_pop_addr", 32'(out_addr), 32'h4);
    step();
    chk("full_w4_level", 32'(level), 32'd4);

    // Scenario 4: flush with simultaneous push and pop
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_addr", 32'(out_addr), 32'h4);

    // Scenario 3: address wrap after base load
    in_valid = 1'b1; in_cmd_code = 4'hC; load_base = 1'b1; base_addr = 16'hFFFF;
    step();
    load_base = 1'b0; in_cmd_code = 4'hD;
    step();
    in_valid = 1'b0;
    chk("wrap_addr_ffff", 32'(out_addr), 32'hFFFF);
    chk("wrap_word_c", out_word, 32'hC000_0000);
    out_ready = 1'b1;
    step();
    chk("wrap_addr_0", 32'(out_addr), 32'h0000);
    chk("wrap_word_d", out_word, 32'hD000_0000);
    step();
    out_ready = 1'b0;
    chk("wrap_addr_1", 32'(out_addr), 32'h0001);

    // Base load overrides a same-cycle pop; the pop still completes
    in_valid = 1'b1; in_cmd_code = 4'hE;
    step();
    in_valid = 1'b0; out_ready = 1'b1; load_base = 1'b1; base_addr = 16'h1234;
    step();
    out_ready = 1'b0; load_base = 1'b0;
    chk("ldpop_level", 32'(level), 32'd0);
    chk("ldpop_addr", 32'(out_addr), 32'h1234);

    // Scenario 5: out-of-range register number
    in_valid = 1'b1; in_reg_num = 16'h0008; in_reg_ptr = 4'b0001; in_cmd_code = 4'h0;
    step();
    in_valid = 1'b0; in_reg_num = '0; in_reg_ptr = '0;
    chk("err_pulse", 32'(err), 32'(ERR_EXP));
    chk("err_trunc_word", out_word, 32'h0000_0008);
    step();
    chk("err_one_cycle", 32'(err), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Scenario 6: reset with three words buffered
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_cmd_code = 4'(i);
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_addr", 32'(out_addr), 32'h0);
    chk("mid_rst_word", out_word, 32'h0);
    in_valid = 1'b1; in_cmd_code = 4'h9;
    step();
    in_valid = 1'b0;
    chk("post_rst_level", 32'(level), 32'd1);
    chk("post_rst_word", out_word, 32'h9000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cmd_word_emitter
